rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N:1 multiplexer with valid/ready handshake on every input and on the output.
- Replaces fixed-select muxing wherever several producers share one consumer, e.g. writeback sources or memory request sources.
- Selection is done by round-robin arbitration instead of an external select line.
- The output is registered: one-beat buffer, latency 1, full throughput.

Parameters:
- WIDTH, 32: data width per channel, >=1.
- NUM_CH, 4: number of input channels, >=2.
- SEL_W, $clog2(NUM_CH): localparam, width of out_sel and of the priority pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational, one-hot or zero.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.

Behaviour:
- Reset: synchronous, active-high, single clock (clk), as already decided.
  - On rst=1 at a clk edge: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - While rst=1, in_ready=0 on all channels.
  - Reset mid-operation discards any held beat, with no output handshake.
- load_en = !out_valid || out_ready. The output register may take a new beat this cycle.
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, ..., wrapping modulo NUM_CH.
  - Grant g = the first channel with in_valid=1.
  - in_ready[g] = load_en && !rst. All other in_ready bits are 0.
  - No valid input: no grant, in_ready=0.
- Transfer on input channel g: in_valid[g] && in_ready[g] at a clk edge. At that edge:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g==NUM_CH-1) ? 0 : g+1.
- load_en=1 with no valid input: out_valid <= 0. out_data and out_sel hold.
- load_en=0 (out_valid=1, out_ready=0): out_data, out_sel and out_valid hold; ptr holds; in_ready=0. Stall is lossless.
- Simultaneous output drain and new input: if out_ready=1 and an input is granted in the same cycle, the old beat leaves and the new beat loads on the same edge. Sustained throughput is 1 beat/cycle.
- Latency: an input accepted at edge N appears on out_* after edge N, i.e. visible in cycle N+1.
- Fairness: a channel that holds in_valid high is granted within NUM_CH transfers.
- ptr changes only on a transfer.
- in_valid may be deasserted before acceptance; the arbiter does not lock onto it.
- in_ready depends combinationally on out_ready (no skid). Consumers must not derive out_ready from in_ready.
- out_sel never exceeds NUM_CH-1. Wrap-around from channel NUM_CH-1 goes to 0.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input port in_last [NUM_CH-1:0] and registered output out_last (reset 0), loaded alongside out_data.
  - After a transfer from channel g with in_last[g]=0, the grant is locked to g: the arbiter ignores other channels until a transfer from g with in_last[g]=1.
  - While locked and in_valid[g]=0, no grant is issued; other channels wait.
  - ptr advances only on the transfer that carries in_last=1.
  - Reset clears the lock.
- Not defined: ports in_last and out_last do not exist; every beat is arbitrated independently as above.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles with in_valid=4'b1111 and out_ready=1.
  - Response: in_ready=0, out_valid=0, out_data=0, out_sel=0 throughout.
- Round robin:
  - Stimulus: NUM_CH=4, all channels valid continuously with data 0xA0+i, out_ready=1.
  - Response: out_sel sequence 0,1,2,3,0,... with out_data 0xA0,0xA1,0xA2,0xA3; out_valid=1 every cycle after the first.
- Backpressure:
  - Stimulus: ch2 sends 0xDEADBEEF, then out_ready=0 for 5 cycles.
  - Response: out_data=0xDEADBEEF, out_sel=2, out_valid=1 held; in_ready=0 for those cycles; no beat lost after out_ready returns.
- Sparse / wrap:
  - Stimulus: ptr=3, only ch1 valid.
  - Response: ch1 granted (wrap 3->0->1); next ptr=2.
- Idle:
  - Stimulus: one beat from ch0, then no valids with out_ready=1.
  - Response: out_valid drops to 0 one cycle after the beat is consumed.
- Lock (RR_ARB_MUX_LOCK_EN):
  - Stimulus: ch0 sends 3 beats (last on the 3rd) while ch1 is valid throughout.
  - Response: out_sel=0,0,0, then 1; out_last=1 only on the 3rd beat.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N:1 round-robin arbitrated multiplexer with valid/ready on every
// input and a registered one-beat output buffer (latency 1, full throughput).
//
// Optional build macro: RR_ARB_MUX_LOCK_EN
//   Adds in_last / out_last. A transfer with in_last=0 locks the grant to its
//   channel until that channel transfers a beat with in_last=1.
//
// in_ready depends combinationally on out_ready; consumers must not derive
// out_ready from in_ready.
module rr_arb_mux #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             load_en;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W:0]   scan_sum;
  logic [SEL_W-1:0] scan_idx;
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] grant_next;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

`ifdef RR_ARB_MUX_LOCK_EN
  logic             lock_q,     lock_d;
  logic [SEL_W-1:0] lock_ch_q,  lock_ch_d;
  logic             out_last_q, out_last_d;
`endif

  assign load_en = !out_valid_q || out_ready;

  // Round-robin scan: first valid channel starting at ptr, wrapping modulo NUM_CH.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (scan_sum >= (SEL_W+1)'(NUM_CH)) begin
        scan_sum = scan_sum - (SEL_W+1)'(NUM_CH);
      end
      scan_idx = scan_sum[SEL_W-1:0];
      if (!rr_found && in_valid[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  // Final grant: a held lock overrides the round-robin choice.
  always_comb begin
    grant_found = rr_found;
    grant_idx   = rr_idx;
`ifdef RR_ARB_MUX_LOCK_EN
    if (lock_q) begin
      grant_found = in_valid[lock_ch_q];
      grant_idx   = lock_ch_q;
    end
`endif
  end

  assign xfer       = grant_found && load_en && !rst;
  assign grant_next = (grant_idx == SEL_W'(NUM_CH-1)) ? '0 : grant_idx + SEL_W'(1);

  // Granted channel's data, selected by comparison to keep index widths exact.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot ready to the granted channel when the output buffer can load.
  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state for the output buffer, pointer and lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (load_en) begin
      out_valid_d = grant_found;
    end
    if (xfer) begin
      out_data_d = grant_data;
      out_sel_d  = grant_idx;
`ifdef RR_ARB_MUX_LOCK_EN
      out_last_d = in_last[grant_idx];
      lock_d     = !in_last[grant_idx];
      lock_ch_d  = grant_idx;
      if (in_last[grant_idx]) begin
        ptr_d = grant_next;
      end
`else
      ptr_d = grant_next;
`endif
    end
  end

  // State registers with synchronous reset; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef RR_ARB_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: directed scenarios plus randomized traffic checked
// against a behavioural model of the arbitration rules.
module tb_rr_arb_mux;
  localparam int WIDTH  = 32;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
`ifdef RR_ARB_MUX_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH-1:0]       in_last;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_last;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int               m_ptr;
  bit               m_ov;
  logic [WIDTH-1:0] m_od;
  logic [SEL_W-1:0] m_os;
  bit               m_ol;
  bit               m_lock;
  int               m_lock_ch;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_last  (in_last),
    .out_last (out_last),
`endif
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sel  (out_sel)
  );

`ifndef RR_ARB_MUX_LOCK_EN
  assign out_last = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [WIDTH-1:0] d);
    in_data[c*WIDTH +: WIDTH] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ov = 0; m_od = '0; m_os = '0; m_ol = 0; m_lock = 0; m_lock_ch = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Grant by the arbitration rules; -1 means no channel is granted.
  function automatic int model_grant();
    if (rst) return -1;
    if (m_ov && !out_ready) return -1;
    if (LOCK && m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // Apply the effect of the coming clock edge to the model.
  task automatic model_edge(input int g);
    if (rst) begin
      model_reset();
    end else if (!m_ov || out_ready) begin
      if (g >= 0) begin
        m_od = in_data[g*WIDTH +: WIDTH];
        m_os = g[SEL_W-1:0];
        m_ov = 1;
        if (LOCK) begin
          m_ol      = in_last[g];
          m_lock    = !in_last[g];
          m_lock_ch = g;
          if (in_last[g]) m_ptr = (g + 1) % NUM_CH;
        end else begin
          m_ptr = (g + 1) % NUM_CH;
        end
      end else begin
        m_ov = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_last = '0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'h100 + c);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL reset_in_ready[%0d] got=%b exp=0000", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || out_last !== 1'b0) begin
        failures++;
        $display("FAIL reset_out[%0d] got valid=%b data=%h sel=%0d exp 0/0/0", i, out_valid, out_data, out_sel);
      end
    end
    rst = 1'b0; in_valid = '0;
    model_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 4'b1111; in_last = 4'b1111;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'hA0 + c);
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'(1 << (i % NUM_CH))) begin
        failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, in_ready, 4'(1 << (i % NUM_CH)));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== SEL_W'(i % NUM_CH) || out_data !== 32'(32'hA0 + i % NUM_CH)) begin
        failures++;
        $display("FAIL rr_out[%0d] got valid=%b sel=%0d data=%h exp 1/%0d/%h",
                 i, out_valid, out_sel, out_data, i % NUM_CH, 32'hA0 + i % NUM_CH);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_last = 4'b1111;
    in_valid = 4'b0100; set_ch(2, 32'hDEADBEEF);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bp_load got valid=%b sel=%0d data=%h exp 1/2/deadbeef", out_valid, out_sel, out_data);
    end
    in_valid = 4'b0001; set_ch(0, 32'h11); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'hDEADBEEF) begin
        failures++; $display("FAIL bp_hold[%0d] got valid=%b sel=%0d data=%h exp 1/2/deadbeef", i, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++; $display("FAIL bp_resume_ready got=%b exp=0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'h11) begin
      failures++; $display("FAIL bp_resume got valid=%b sel=%0d data=%h exp 1/0/11", out_valid, out_sel, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    in_last = 4'b1111;
    in_valid = 4'b0100; set_ch(2, 32'h22);
    tick();
    in_valid = 4'b0010; set_ch(1, 32'h55);
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL wrap_ready got=%b exp=0010", in_ready);
    end
    tick();
    checks++;
    if (out_sel !== 2'd1 || out_data !== 32'h55) begin
      failures++; $display("FAIL wrap_out got sel=%0d data=%h exp 1/55", out_sel, out_data);
    end
    in_valid = 4'b1101; set_ch(0, 32'h0); set_ch(2, 32'h2); set_ch(3, 32'h3);
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++; $display("FAIL wrap_next_ready got=%b exp=0100", in_ready);
    end
    tick();
    checks++;
    if (out_sel !== 2'd2 || out_data !== 32'h2) begin
      failures++; $display("FAIL wrap_next_out got sel=%0d data=%h exp 2/2", out_sel, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_idle();
    do_reset();
    in_last = 4'b1111;
    in_valid = 4'b0001; set_ch(0, 32'h77);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77) begin
      failures++; $display("FAIL idle_beat got valid=%b data=%h exp 1/77", out_valid, out_data);
    end
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h77 || out_sel !== 2'd0) begin
      failures++; $display("FAIL idle_drop got valid=%b data=%h sel=%0d exp 0/77/0", out_valid, out_data, out_sel);
    end
  endtask

`ifdef RR_ARB_MUX_LOCK_EN
  task automatic test_lock();
    do_reset();
    in_valid = 4'b0011; set_ch(1, 32'hC1); in_last = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 32'hB0 + k);
      in_last[0] = (k == 2);
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
        failures++; $display("FAIL lock_ready[%0d] got=%b exp=0001", k, in_ready);
      end
      tick();
      checks++;
      if (out_sel !== 2'd0 || out_last !== (k == 2) || out_data !== 32'(32'hB0 + k)) begin
        failures++; $display("FAIL lock_beat[%0d] got sel=%0d last=%b data=%h exp 0/%0d/%h",
                             k, out_sel, out_last, out_data, (k == 2), 32'hB0 + k);
      end
    end
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL lock_release_ready got=%b exp=0010", in_ready);
    end
    tick();
    checks++;
    if (out_sel !== 2'd1 || out_last !== 1'b1 || out_data !== 32'hC1) begin
      failures++; $display("FAIL lock_release got sel=%0d last=%b data=%h exp 1/1/c1", out_sel, out_last, out_data);
    end
    in_valid = '0;
    tick();
  endtask
`endif

  task automatic test_random();
    int g;
    logic [NUM_CH-1:0] exp_ready;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = 4'($urandom_range(0, 15));
      in_last   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CH; c++) set_ch(c, $urandom);
      #1;
      g = model_grant();
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++;
      if (in_ready !== exp_ready) begin
        failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready);
      end
      model_edge(g);
      tick();
      checks++;
      if (out_valid !== m_ov || out_data !== m_od || out_sel !== m_os || (LOCK && out_last !== m_ol)) begin
        failures++;
        $display("FAIL rand_out[%0d] got valid=%b data=%h sel=%0d last=%b exp %b/%h/%0d/%b",
                 i, out_valid, out_data, out_sel, out_last, m_ov, m_od, m_os, m_ol);
      end
    end
    rst = 1'b0; in_valid = '0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_idle();
`ifdef RR_ARB_MUX_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
